median_filter_array: RTL
========================

Name: median_filter_array

Overview:
- Parametrised sliding-window median filter. It generalises the single median cell into a complete filter: a sorted register array, an age-ordered history, a fill counter, runtime window selection, and valid/ready handshakes on both sides.
- Sits between a streaming sample source and downstream DSP. It emits one median per accepted sample once the window is full.

Parameters:
- DATA_LENGTH, 32, sample width in bits.
- WMAX, 15, maximum window length; must be odd and ≥ 1.
- LOG_WMAX, 4, width of window/count fields; must satisfy 2^LOG_WMAX > WMAX.
- SIGNED, 0, 1 = two's-complement comparison, 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- W  in  LOG_WMAX  runtime window length; legal values are odd and 1..WMAX.
- flush  in  1  synchronous clear of window contents; W is kept.
- in_data  in  DATA_LENGTH  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  filter accepts a sample this cycle.
- out_median  out  DATA_LENGTH  median of the last W accepted samples.
- out_valid  out  1  out_median is valid.
- out_ready  in  1  downstream accepts the output.
- fill  out  LOG_WMAX  number of samples currently held in the window (0..W).
- cfg_err  out  1  W is illegal.

Behaviour:
- Reset (reset=0): all sorted and age registers become 0; fill=0; out_valid=0; out_median=0; cfg_err=0; W_reg=0.
- Registered window: W_reg captures W every cycle after reset.
  - If W differs from W_reg, the window is cleared the same way as a flush.
- cfg_err = (W==0) | (W even) | (W>WMAX), combinational.
  - While cfg_err=1, in_ready=0 and no state changes except the W_reg update.
- Handshake:
  - in_ready = !cfg_err & (!out_valid | out_ready).
  - A sample is accepted when in_valid & in_ready.
  - The output stage is a single register. out_valid/out_median stay stable until out_ready=1.
- Accept with fill < W:
  - Insert in_data into the sorted array, descending order (index 0 = largest).
  - Shift the age array: A[0] ← in_data, A[i] ← A[i-1].
  - fill increments.
- Accept with fill == W:
  - In the same cycle, delete one instance of A[W-1] (the oldest) and insert in_data.
  - Shift the age array. fill is unchanged.
  - Net behaviour: the sorted array equals a descending sort of A[0..W-1].
  - Duplicates: removing any equal instance is acceptable, since the resulting multiset is identical.
- Per-cell move selection, i.e. keep / take new / shift from left / shift from right, is decided from two compares per cell: new > S[i] and old > S[i]. The decision uses the same S[i-1]/S[i+1] neighbour flags as the existing cell.
- Latency:
  - When an accept brings fill to W (or fill was already W), out_median ← S'[(W-1)/2] and out_valid ← 1 on the next clk edge.
  - S' is the post-update array; latency is 1 cycle.
- Output clearing: if out_ready=1 and there is no new median that cycle, out_valid ← 0.
- flush=1 (or a W change): fill ← 0, out_valid ← 0, sorted/age arrays ← 0.
  - flush has priority over a simultaneous accept; that sample is discarded.
- Entries at index ≥ W are don't-care and are never used in median selection.
- W=1: the median equals the sample just accepted, out 1 cycle later.
- Comparison is signed or unsigned per SIGNED. Equal values are never "greater".

Optional Feature:
- Macro MEDIAN_MINMAX_EN.
- Defined:
  - Adds outputs out_min and out_max (DATA_LENGTH each), holding S'[W-1] and S'[0].
  - They are registered alongside out_median, share out_valid, and reset to 0.
- Undefined: the ports are absent and no extra registers are built.

Test Plan:
- W=3, unsigned, samples 5,1,9,3,7, out_ready=1 → medians 5,3,7 on the cycles after the 3rd, 4th and 5th accepts. fill goes 1,2,3,3,3.
- W=5, samples 10,20,30,40,50,5,5 → medians 30,30,30. Then flush=1 → fill=0, out_valid=0, and the next sample produces no output.
- Backpressure: W=3, samples 5,1,9 then hold out_ready=0 → out_median=5 is held and in_ready=0. Raise out_ready → the next accepted sample 3 gives 3.
- Illegal W=4 → cfg_err=1, in_ready=0. Change to W=3 → cfg_err=0, fill=0, normal operation.
- SIGNED=1, W=3, samples -2,7,-9 → median -2. Drive reset low mid-stream → all outputs 0 on the next edge.
- MEDIAN_MINMAX_EN, W=3, samples 5,1,9 → out_min=1, out_max=9, out_median=5.

Source files
------------

// File: rtl/median_filter_array.sv
// Sliding-window median filter. It keeps a descending sorted array and an age-ordered history.
// The optional out_min/out_max outputs are enabled by defining MEDIAN_MINMAX_EN.
module median_filter_array #(
  parameter int DATA_LENGTH = 32,
  parameter int WMAX        = 15,
  parameter int LOG_WMAX    = 4,
  parameter int SIGNED      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LOG_WMAX-1:0]    W,
  input  logic                   flush,
  input  logic [DATA_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_LENGTH-1:0] out_median,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LOG_WMAX-1:0]    fill,
  output logic                   cfg_err
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [DATA_LENGTH-1:0] out_min,
  output logic [DATA_LENGTH-1:0] out_max
`endif
);
  typedef logic [DATA_LENGTH-1:0] data_t;
  typedef logic [LOG_WMAX-1:0]    cnt_t;

  data_t sort_q [WMAX];
  data_t sort_d [WMAX];
  data_t age_q  [WMAX];
  data_t age_d  [WMAX];
  cnt_t  fill_q, w_q;
  data_t med_q, med_d;
  logic  out_valid_q;
  logic  gn [WMAX];
  logic  go [WMAX];
  logic  accept, clear, full, new_median;
  cnt_t  lim;
  data_t old_s;

  function automatic logic gt(input data_t a, input data_t b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Valid/ready: a sample moves when in_valid & in_ready; out_median/out_valid hold until out_ready.
  assign cfg_err    = (W == '0) | ~W[0] | (W > cnt_t'(WMAX));
  assign in_ready   = ~cfg_err & (~out_valid_q | out_ready);
  assign accept     = in_valid & in_ready;
  assign clear      = ~cfg_err & (flush | (W != w_q));
  assign full       = (fill_q == w_q);
  assign lim        = full ? w_q : fill_q;
  assign new_median = accept & (full | ((fill_q + cnt_t'(1)) == w_q));

  // While filling, the deleted "old" entry is a virtual minimum in the empty slot at fill_q.
  always_comb begin
    old_s = '0;
    for (int i = 0; i < WMAX; i++)
      if (cnt_t'(i) == w_q - cnt_t'(1)) old_s = age_q[i];
    for (int i = 0; i < WMAX; i++) begin
      gn[i] = (cnt_t'(i) >= lim) | gt(in_data, sort_q[i]);
      go[i] = full ? ((cnt_t'(i) >= lim) | gt(old_s, sort_q[i])) : (cnt_t'(i) > fill_q);
    end
    for (int i = 0; i < WMAX; i++) begin
      logic  l_gn, r_gn, r_go;
      data_t l_s, r_s, l_age;
      l_gn  = 1'b0;
      l_s   = '0;
      l_age = in_data;
      r_gn  = 1'b1;
      r_go  = 1'b1;
      r_s   = '0;
      if (i > 0) begin
        l_gn  = gn[i-1];
        l_s   = sort_q[i-1];
        l_age = age_q[i-1];
      end
      if (i < WMAX - 1) begin
        r_gn = gn[i+1];
        r_go = go[i+1];
        r_s  = sort_q[i+1];
      end
      sort_d[i] = sort_q[i];
      if (gn[i] & ~go[i])       sort_d[i] = l_gn ? l_s : in_data;
      else if (~gn[i] & r_go)   sort_d[i] = r_gn ? in_data : r_s;
      age_d[i] = l_age;
    end
    med_d = '0;
    for (int i = 0; i < WMAX; i++)
      if (cnt_t'(i) == ((w_q - cnt_t'(1)) >> 1)) med_d = sort_d[i];
  end

`ifdef MEDIAN_MINMAX_EN
  data_t min_q, max_q, min_d;
  always_comb begin
    min_d = '0;
    for (int i = 0; i < WMAX; i++)
      if (cnt_t'(i) == w_q - cnt_t'(1)) min_d = sort_d[i];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      min_q <= '0;
      max_q <= '0;
    end else if (!clear && new_median) begin
      min_q <= min_d;
      max_q <= sort_d[0];
    end
  end
  assign out_min = min_q;
  assign out_max = max_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sort_q      <= '{default: '0};
      age_q       <= '{default: '0};
      fill_q      <= '0;
      w_q         <= '0;
      med_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      w_q <= W;
      if (clear) begin
        sort_q      <= '{default: '0};
        age_q       <= '{default: '0};
        fill_q      <= '0;
        out_valid_q <= 1'b0;
      end else if (!cfg_err) begin
        if (accept) begin
          sort_q <= sort_d;
          age_q  <= age_d;
          if (!full) fill_q <= fill_q + cnt_t'(1);
        end
        if (new_median) begin
          out_valid_q <= 1'b1;
          med_q       <= med_d;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign fill       = fill_q;
  assign out_valid  = out_valid_q;
  assign out_median = med_q;
endmodule
